row_buffer_scheduler: RTL and testbench

ROW_BUFFER_SCHEDULER -- requirements
Module: row_buffer_scheduler

---
 rtl/row_buffer_scheduler_pkg.sv | 23 ++
 rtl/row_buffer_tracker.sv | 50 +++++
 rtl/row_buffer_scheduler.sv | 161 ++++++++++++++++
 tb/tb_row_buffer_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/row_buffer_scheduler_pkg.sv
// rtl/row_buffer_scheduler_pkg.sv - shared command codes, scheduler states and counter width
// Also imported by the memory-side controller so both ends agree on cmd_data encoding.
package row_buffer_scheduler_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    CMD_NOP         = 2'd0,
    CMD_FRAME_START = 2'd1,
    CMD_ROW_READY   = 2'd2,
    CMD_FRAME_END   = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE             = 3'd0,
    ST_SEND_FRAME_START = 3'd1,
    ST_FILL_ROW         = 3'd2,
    ST_SEND_ROW         = 3'd3,
    ST_WAIT_BUF         = 3'd4,
    ST_SEND_FRAME_END   = 3'd5
  } state_e;

endpackage

// File: rtl/row_buffer_tracker.sv
// rtl/row_buffer_tracker.sv - ping-pong ownership of row buffers A/B
// Tracks which buffer is being written, which the memory side reads next, and which hold a full row.
module row_buffer_tracker (
  input  logic clk_cam,
  input  logic reset_n,
  input  logic row_done_i,
  input  logic wr_toggle_i,
  input  logic buf_release_i,
  output logic wr_buf_o,
  output logic rd_buf_sel_o,
  output logic wr_buf_full_o,
  output logic next_buf_full_o,
  output logic release_err_o
);

  logic [1:0] full_q, full_d;
  logic       wr_buf_q, wr_buf_d;
  logic       rd_sel_q, rd_sel_d;
  logic       release_ok;

  assign release_ok = buf_release_i & full_q[rd_sel_q];

  // Release is applied before the row-done set so a coincident completion is never lost.
  always_comb begin
    full_d = full_q;
    if (release_ok) full_d[rd_sel_q] = 1'b0;
    if (row_done_i) full_d[wr_buf_q] = 1'b1;
    rd_sel_d = rd_sel_q ^ release_ok;
    wr_buf_d = wr_buf_q ^ wr_toggle_i;
  end

  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 2'b00;
      wr_buf_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_buf_q <= wr_buf_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  assign wr_buf_o        = wr_buf_q;
  assign rd_buf_sel_o    = rd_sel_q;
  assign wr_buf_full_o   = full_q[wr_buf_q];
  assign next_buf_full_o = full_q[~wr_buf_q];
  assign release_err_o   = buf_release_i & ~full_q[rd_sel_q];

endmodule

// File: rtl/row_buffer_scheduler.sv
// rtl/row_buffer_scheduler.sv - packs camera pixels into ping-pong row buffers and sequences memory commands
// Pixels are paired into 32-bit words; each completed row is announced with ROW_READY.
module row_buffer_scheduler
  import row_buffer_scheduler_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk_cam,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        wr_en_a,
  output logic        wr_en_b,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [1:0]  cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        rd_buf_sel,
  input  logic        buf_release,
  output logic        frame_done,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(FRAME_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(FRAME_HEIGHT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [9:0]       wr_addr_q, wr_addr_d;
  logic             wr_en_a_q, wr_en_a_d, wr_en_b_q, wr_en_b_d;
  logic             err_q, err_d;

  logic wr_buf, wr_buf_full, next_buf_full, release_err;
  logic accept, last_pix, wr_toggle;

  assign accept    = pix_valid & pix_ready;
  assign last_pix  = accept & (col_q == LAST_COL);
  assign wr_toggle = (state_q == ST_SEND_ROW) & cmd_ready;

  row_buffer_tracker u_tracker (
    .clk_cam        (clk_cam),
    .reset_n        (reset_n),
    .row_done_i     (last_pix),
    .wr_toggle_i    (wr_toggle),
    .buf_release_i  (buf_release),
    .wr_buf_o       (wr_buf),
    .rd_buf_sel_o   (rd_buf_sel),
    .wr_buf_full_o  (wr_buf_full),
    .next_buf_full_o(next_buf_full),
    .release_err_o  (release_err)
  );

  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:             if (frame_start) state_d = ST_SEND_FRAME_START;
      ST_SEND_FRAME_START: if (cmd_ready) state_d = wr_buf_full ? ST_WAIT_BUF : ST_FILL_ROW;
      ST_FILL_ROW:         if (last_pix) state_d = ST_SEND_ROW;
      ST_SEND_ROW: begin
        if (cmd_ready) begin
          if (row_q == ROWS)      state_d = ST_SEND_FRAME_END;
          else if (next_buf_full) state_d = ST_WAIT_BUF;
          else                    state_d = ST_FILL_ROW;
        end
      end
      ST_WAIT_BUF:         if (!wr_buf_full) state_d = ST_FILL_ROW;
      ST_SEND_FRAME_END:   if (cmd_ready) state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = 1'b0;
    cmd_valid  = 1'b0;
    cmd_data   = CMD_NOP;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_SEND_FRAME_START: begin
        cmd_valid = 1'b1;
        cmd_data  = CMD_FRAME_START;
      end
      ST_FILL_ROW: pix_ready = 1'b1;
      ST_SEND_ROW: begin
        cmd_valid = 1'b1;
        cmd_data  = CMD_ROW_READY;
      end
      ST_SEND_FRAME_END: begin
        cmd_valid  = 1'b1;
        cmd_data   = CMD_FRAME_END;
        frame_done = cmd_ready;
      end
      default: ;
    endcase
  end

  // Odd pixel completes a word; the write strobe goes out on the following cycle.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_a_d = 1'b0;
    wr_en_b_d = 1'b0;
    err_d     = err_q | release_err | (frame_start & (state_q != ST_IDLE));
    if (state_q == ST_IDLE && frame_start) begin
      col_d = '0;
      row_d = '0;
    end
    if (accept) begin
      if (!col_q[0]) begin
        wr_data_d[15:0] = pix_data;
      end else begin
        wr_data_d[31:16] = pix_data;
        wr_addr_d        = col_q[10:1];
        wr_en_a_d        = ~wr_buf;
        wr_en_b_d        = wr_buf;
      end
      col_d = last_pix ? '0 : col_q + CNT_W'(1);
      if (last_pix) row_d = row_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_cam or negedge reset_n) begin
    if (!reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_a_q <= 1'b0;
      wr_en_b_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_a_q <= wr_en_a_d;
      wr_en_b_q <= wr_en_b_d;
      err_q     <= err_d;
    end
  end

  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;
  assign wr_en_a = wr_en_a_q;
  assign wr_en_b = wr_en_b_q;
  assign err     = err_q;

endmodule

// File: tb/tb_row_buffer_scheduler.sv
// tb/tb_row_buffer_scheduler.sv - directed bench for row_buffer_scheduler at 8x3 frames
module tb_row_buffer_scheduler;

  logic        clk_cam = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        cmd_ready = 1'b0;
  logic        buf_release = 1'b0;
  logic        pix_ready, wr_en_a, wr_en_b, cmd_valid, rd_buf_sel, frame_done, busy, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  cmd_data;

  row_buffer_scheduler #(.FRAME_WIDTH(8), .FRAME_HEIGHT(3)) dut (
    .clk_cam(clk_cam), .reset_n(reset_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rd_buf_sel(rd_buf_sel), .buf_release(buf_release),
    .frame_done(frame_done), .busy(busy), .err(err)
  );

  always #5 clk_cam = ~clk_cam;

  int n_chk = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int both_en = 0;
  logic [42:0] wq[$];
  logic [1:0]  cq[$];

  always @(negedge clk_cam) begin
    if (wr_en_a && wr_en_b) both_en++;
    if (wr_en_a) wq.push_back({1'b0, wr_addr, wr_data});
    if (wr_en_b) wq.push_back({1'b1, wr_addr, wr_data});
    if (cmd_valid && cmd_ready) cq.push_back(cmd_data);
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_cam);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {12'd0, pix_ready, wr_en_a, wr_en_b, wr_addr, wr_data,
            cmd_valid, cmd_data, rd_buf_sel, frame_done, busy, err};
  endfunction

  function automatic logic [63:0] pack_cmds();
    logic [31:0] v = '0;
    foreach (cq[i]) v = (v << 2) | 32'(cq[i]);
    return {32'(cq.size()), v};
  endfunction

  task automatic send_pixel(input logic [15:0] d);
    bit done = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    for (int t = 0; t < 20 && !done; t++) begin
      if (pix_ready) done = 1;
      step();
    end
    pix_valid = 1'b0;
    if (!done) chk("pix_timeout", 0, 1);
  endtask

  task automatic send_row(input logic [15:0] base);
    for (int k = 0; k < 8; k++) send_pixel(base + 16'(k));
  endtask

  task automatic pulse_release();
    buf_release = 1'b1;
    step();
    buf_release = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("reset_outs", outs(), 64'd0);
    reset_n = 1'b1;
    step();

    // frame 1: row into A, stalled ROW_READY, WAIT_BUF, late releases
    cmd_ready = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    send_row(16'h0001);
    step();
    chk("r1_nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("r1_wr%0d", i), (i < wq.size()) ? wq[i] : '1,
          {1'b0, 10'(i), 16'(2 * i + 2), 16'(2 * i + 1)});
    chk("r1_cmds", pack_cmds(), {32'd2, 32'b0110});
    chk("r1_rdsel", rd_buf_sel, 0);

    cmd_ready = 1'b0;
    wq.delete();
    send_row(16'h0011);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d", i), {cmd_valid, cmd_data}, 3'b110);
      step();
    end
    chk("stall_nohs", cq.size(), 2);
    cmd_ready = 1'b1;
    step();
    chk("r2_hs", cq.size(), 3);
    chk("r2_nwr", wq.size(), 4);
    chk("r2_last", (wq.size() == 4) ? wq[3] : '1, {1'b1, 10'd3, 32'h00180017});
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait%0d", i), {busy, pix_ready, cmd_valid}, 3'b100);
      step();
    end
    pulse_release();
    chk("rel_rdsel", rd_buf_sel, 1);
    chk("rel_still_wait", pix_ready, 0);
    step();
    chk("rel_fill", pix_ready, 1);
    pulse_release();
    wq.delete();
    send_row(16'h0021);
    step();
    step();
    chk("r3_first", (wq.size() > 0) ? wq[0] : '1, {1'b0, 10'd0, 32'h00220021});
    chk("f1_cmds", pack_cmds(), {32'd5, 32'h1AB});
    chk("f1_done", fd_cnt, 1);
    chk("f1_busy_err", {busy, err}, 2'b00);
    pulse_release();
    chk("f1_clean_err", err, 0);

    // frame 2: prompt release after every row
    cq.delete(); wq.delete(); fd_cnt = 0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      send_row(16'h0100 * 16'(r + 1));
      step();
      pulse_release();
    end
    chk("f2_cmds", pack_cmds(), {32'd5, 32'h1AB});
    chk("f2_done", fd_cnt, 1);
    chk("f2_busy_err", {busy, err}, 2'b00);
    chk("f2_nwr", wq.size(), 12);
    chk("f2_first_buf", (wq.size() > 0) ? wq[0][42] : 1'b0, 1);
    chk("f2_rdsel", rd_buf_sel, 0);
    chk("both_en", both_en, 0);

    // release with nothing full
    pulse_release();
    chk("rel_err", err, 1);
    chk("rel_err_idle", {busy, rd_buf_sel}, 2'b00);

    // frame_start while filling, then reset mid-row
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    chk("rst_err_clear", err, 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step();
    chk("fill_state", pix_ready, 1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("fs_fill_err", err, 1);
    chk("fs_fill_state", {pix_ready, cmd_valid}, 2'b10);
    for (int k = 0; k < 5; k++) send_pixel(16'h0031 + 16'(k));
    chk("pre_rst_data", wr_data, 32'h00340035);
    reset_n = 1'b0;
    #2;
    chk("midrst_outs", outs(), 64'd0);
    step();
    reset_n = 1'b1;
    cq.delete(); wq.delete();
    repeat (4) step();
    chk("no_cmd_after_rst", cq.size(), 0);
    chk("idle_after_rst", busy, 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    send_pixel(16'h0041);
    send_pixel(16'h0042);
    step();
    chk("restart_wr", (wq.size() > 0) ? wq[0] : '1, {1'b0, 10'd0, 32'h00420041});
    chk("restart_cmd", (cq.size() > 0) ? cq[0] : 2'd0, 2'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
